// File: rtl/acc_array_ctrl.sv
// Skewed accumulator array controller: a group counter produces a clear strobe that is
// delayed column by column, so each lane accumulates, reports its sum and restarts in turn.
module acc_array_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int NUM_CH     = 4,
    parameter int A_BITS     = 8,
    parameter int Z_BITS     = 12,
    parameter int SATURATE   = 0,
    localparam int CNT_W     = $clog2(ARRAY_SIZE + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid,
    input  logic                                interrupt,
    input  logic [CNT_W-1:0]                    acc_len,
    input  logic [NUM_CH*ARRAY_SIZE*A_BITS-1:0] in_data,
    output logic [NUM_CH*ARRAY_SIZE*Z_BITS-1:0] result,
    output logic [ARRAY_SIZE-1:0]               res_valid,
    output logic [ARRAY_SIZE-1:0]               res_abort,
    output logic [NUM_CH*ARRAY_SIZE-1:0]        ovf,
    output logic [CNT_W-1:0]                    selector_out,
    output logic                                clear_out
);
    localparam int LANES = NUM_CH * ARRAY_SIZE;

    logic [CNT_W-1:0]      cnt_q, cnt_d, len_q, len_in, len_eff;
    logic                  clear;
    logic [ARRAY_SIZE-1:0] clr_q, vld_q, abt_q, rv_q, ra_q;
    logic [Z_BITS-1:0]     acc_q [LANES];
    logic [Z_BITS-1:0]     acc_d [LANES];
    logic [Z_BITS-1:0]     res_q [LANES];
    logic [Z_BITS-1:0]     res_d [LANES];
    logic [LANES-1:0]      ovf_q, ovf_d;

    // The length is sampled live while idle so an L=1 group can clear on its first valid.
    always_comb begin
        len_in = acc_len;
        if (acc_len == '0 || acc_len > CNT_W'(ARRAY_SIZE))
            len_in = CNT_W'(ARRAY_SIZE);
        len_eff = (cnt_q == '0) ? len_in : len_q;
        clear   = (valid && (cnt_q == len_eff - CNT_W'(1))) || interrupt;
        cnt_d   = cnt_q;
        if (clear)
            cnt_d = '0;
        else if (valid)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            len_q <= CNT_W'(ARRAY_SIZE);
            clr_q <= '0;
            vld_q <= '0;
            abt_q <= '0;
            rv_q  <= '0;
            ra_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_q == '0)
                len_q <= len_in;
            clr_q <= {clr_q[ARRAY_SIZE-2:0], clear};
            vld_q <= {vld_q[ARRAY_SIZE-2:0], valid};
            abt_q <= {abt_q[ARRAY_SIZE-2:0], interrupt};
            rv_q  <= clr_q;
            ra_q  <= clr_q & abt_q;
        end
    end

    always_comb begin
        int unsigned      k;
        logic [Z_BITS:0]  add;
        logic [Z_BITS:0]  sum;
        logic [Z_BITS-1:0] nxt;
        for (int unsigned i = 0; i < LANES; i++) begin
            k   = i % ARRAY_SIZE;
            add = vld_q[k] ? (Z_BITS+1)'(in_data[i*A_BITS +: A_BITS]) : '0;
            sum = {1'b0, acc_q[i]} + add;
            nxt = (SATURATE != 0 && sum[Z_BITS]) ? '1 : sum[Z_BITS-1:0];
            acc_d[i] = acc_q[i];
            res_d[i] = res_q[i];
            // Overflow survives the clear edge so it is visible alongside the strobe.
            ovf_d[i] = (ovf_q[i] & ~rv_q[k]) | sum[Z_BITS];
            if (clr_q[k]) begin
                res_d[i] = nxt;
                acc_d[i] = '0;
            end else if (vld_q[k]) begin
                acc_d[i] = nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                acc_q[i] <= acc_d[i];
                res_q[i] <= res_d[i];
            end
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        result = '0;
        for (int unsigned i = 0; i < LANES; i++)
            result[i*Z_BITS +: Z_BITS] = res_q[i];
    end

    assign res_valid    = rv_q;
    assign res_abort    = ra_q;
    assign ovf          = ovf_q;
    assign selector_out = cnt_q;
    assign clear_out    = clr_q[ARRAY_SIZE-1];
endmodule

// File: tb/tb_acc_array_ctrl.sv
// Scoreboard bench for acc_array_ctrl: a default instance plus two Z_BITS=9 instances
// (saturating and wrapping) share stimulus; expected strobes are queued per column.
module tb_acc_array_ctrl;
    localparam int AS = 4;
    localparam int NC = 4;
    localparam int A  = 8;
    localparam int Z  = 12;
    localparam int CW = 3;

    typedef struct packed {
        int unsigned    cyc;
        logic [NC*Z-1:0] vals;
        logic           ab;
        logic [NC-1:0]  ov;
    } exp_t;

    logic              clk, rst, valid, interrupt;
    logic [CW-1:0]     acc_len;
    logic [NC*AS*A-1:0] in_data;

    logic [NC*AS*Z-1:0] res;
    logic [AS-1:0]      rv, ra;
    logic [NC*AS-1:0]   ovf;
    logic [CW-1:0]      sel;
    logic               clr_o;

    logic [NC*AS*9-1:0] res_s, res_w;
    logic [AS-1:0]      rv_s, ra_s, rv_w, ra_w;
    logic [NC*AS-1:0]   ovf_s, ovf_w;
    logic [CW-1:0]      sel_s, sel_w;
    logic               clr_s, clr_w;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned n;
    exp_t qd[AS][$];
    exp_t qs[$];
    exp_t qw[$];

    acc_array_ctrl u_dut (
        .clk(clk), .rst(rst), .valid(valid), .interrupt(interrupt), .acc_len(acc_len),
        .in_data(in_data), .result(res), .res_valid(rv), .res_abort(ra), .ovf(ovf),
        .selector_out(sel), .clear_out(clr_o)
    );

    acc_array_ctrl #(.Z_BITS(9), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .valid(valid), .interrupt(interrupt), .acc_len(acc_len),
        .in_data(in_data), .result(res_s), .res_valid(rv_s), .res_abort(ra_s), .ovf(ovf_s),
        .selector_out(sel_s), .clear_out(clr_s)
    );

    acc_array_ctrl #(.Z_BITS(9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .valid(valid), .interrupt(interrupt), .acc_len(acc_len),
        .in_data(in_data), .result(res_w), .res_valid(rv_w), .res_abort(ra_w), .ovf(ovf_w),
        .selector_out(sel_w), .clear_out(clr_w)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [NC*Z-1:0] rep(input int unsigned v);
        logic [NC*Z-1:0] r;
        for (int c = 0; c < NC; c++) r[c*Z +: Z] = Z'(v);
        return r;
    endfunction

    task automatic push_col(input int unsigned k, input int unsigned src, input logic [NC*Z-1:0] v,
                            input logic ab);
        exp_t e;
        e.cyc = src + 1 + k;
        e.vals = v;
        e.ab = ab;
        e.ov = '0;
        qd[k].push_back(e);
    endtask

    task automatic push_all(input int unsigned src, input int unsigned v, input logic ab);
        for (int unsigned k = 0; k < AS; k++) push_col(k, src, rep(v), ab);
    endtask

    task automatic set_in(input logic [A-1:0] v);
        for (int i = 0; i < NC*AS; i++) in_data[i*A +: A] = v;
    endtask

    task automatic step(input logic v, input logic intr);
        valid = v;
        interrupt = intr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0);
    endtask

    // Default-instance monitor: every strobe on every column must match a queued entry.
    always @(negedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < AS; k++) begin
                if (rv[k]) begin
                    if (qd[k].size() == 0) begin
                        check("unexpected_strobe", 64'(k + 1), 64'd0);
                    end else begin
                        exp_t e;
                        logic [NC*Z-1:0] got;
                        logic [NC-1:0]   gov;
                        e = qd[k].pop_front();
                        for (int c = 0; c < NC; c++) begin
                            got[c*Z +: Z] = res[(c*AS + int'(k))*Z +: Z];
                            gov[c] = ovf[c*AS + int'(k)];
                        end
                        check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                        check("result_col", 64'(got), 64'(e.vals));
                        check("res_abort", 64'(ra[k]), 64'(e.ab));
                        check("ovf_at_strobe", 64'(gov), 64'(e.ov));
                    end
                end
            end
            if (rv_s[0] && qs.size() != 0) begin
                exp_t e;
                e = qs.pop_front();
                check("sat_cycle", 64'(cyc), 64'(e.cyc));
                check("sat_result", 64'(res_s[8:0]), 64'(e.vals[8:0]));
                check("sat_ovf", 64'(ovf_s[0]), 64'(e.ov[0]));
            end
            if (rv_w[0] && qw.size() != 0) begin
                exp_t e;
                e = qw.pop_front();
                check("wrap_cycle", 64'(cyc), 64'(e.cyc));
                check("wrap_result", 64'(res_w[8:0]), 64'(e.vals[8:0]));
                check("wrap_ovf", 64'(ovf_w[0]), 64'(e.ov[0]));
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b0;
        valid = 1'b0;
        interrupt = 1'b0;
        acc_len = 3'd4;
        in_data = '0;
        #2;
        check("rst_result", 64'(|res), 64'd0);
        check("rst_strobes", 64'({rv, ra}), 64'd0);
        check("rst_ovf_sel_clr", 64'({ovf, sel, clr_o}), 64'd0);
        check("rst_z9", 64'({|res_s, |res_w, rv_s, ra_s, rv_w, ra_w, |ovf_s, |ovf_w,
                             sel_s, sel_w, clr_s, clr_w}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;

        // Single lane (0,0) = 1, L=4
        in_data[A-1:0] = 8'd1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n = cyc;
        for (int unsigned k = 0; k < AS; k++) push_col(k, n, (k == 0) ? rep(0) | (NC*Z)'(4) : rep(0), 1'b0);
        check("sel_after_group", 64'(sel), 64'd0);
        idle(2);
        check("clear_out_early", 64'(clr_o), 64'd0);
        idle(1);
        check("clear_out_last_col", 64'(clr_o), 64'd1);
        idle(6);

        // L=2 continuous, all lanes 5
        acc_len = 3'd2;
        set_in(8'd5);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (i % 2 == 1) push_all(cyc, 10, 1'b0);
        end
        idle(8);

        // Interrupt on second valid, in=3
        acc_len = 3'd4;
        set_in(8'd3);
        step(1'b1, 1'b0);
        check("sel_count1", 64'(sel), 64'd1);
        step(1'b1, 1'b1);
        push_all(cyc, 6, 1'b1);
        check("sel_after_abort", 64'(sel), 64'd0);
        idle(8);

        // acc_len=0 acts as 4; mid-group length change deferred; L=1 back-to-back
        acc_len = 3'd0;
        set_in(8'd2);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("sel_len0", 64'(sel), 64'd3);
        step(1'b1, 1'b0);
        push_all(cyc, 8, 1'b0);
        acc_len = 3'd4;
        step(1'b1, 1'b0);
        acc_len = 3'd1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        push_all(cyc, 8, 1'b0);
        step(1'b1, 1'b0);
        push_all(cyc, 2, 1'b0);
        step(1'b1, 1'b0);
        push_all(cyc, 2, 1'b0);
        idle(8);

        // 255 x 4: default fits, Z=9 saturates / wraps
        acc_len = 3'd4;
        set_in(8'd255);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        n = cyc;
        push_all(n, 1020, 1'b0);
        e.cyc = n + 1; e.vals = (NC*Z)'(511); e.ab = 1'b0; e.ov = 4'b0001;
        qs.push_back(e);
        e.vals = (NC*Z)'(508);
        qw.push_back(e);
        check("sat_ovf_midgroup", 64'(ovf_s[0]), 64'd1);
        idle(2);
        check("sat_ovf_cleared", 64'(ovf_s[0]), 64'd0);
        check("wrap_ovf_cleared", 64'(ovf_w[0]), 64'd0);
        check("sat_result_hold", 64'(res_s[8:0]), 64'd511);
        idle(6);

        // Reset mid-group, then a clean group
        set_in(8'd1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst_result", 64'(|res), 64'd0);
        check("midrst_strobes", 64'({rv, ra}), 64'd0);
        check("midrst_ovf_sel_clr", 64'({ovf, sel, clr_o}), 64'd0);
        idle(2);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        push_all(cyc, 4, 1'b0);
        idle(8);

        for (int unsigned k = 0; k < AS; k++) check("queue_drained", 64'(qd[k].size()), 64'd0);
        check("sat_queue_drained", 64'(qs.size()), 64'd0);
        check("wrap_queue_drained", 64'(qw.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
